// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-wide RAM/IO memory controller: line geometry,
// access-size codes, IO region tag and FSM state encodings.
package mem_ctrl_pkg;

  localparam int LINE_BYTES     = 64;
  localparam int ICACHE_BLOCK_W = 8 * LINE_BYTES;
  localparam int CNT_W          = 7;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_IF_READ  = 3'd1;
  localparam logic [2:0] ST_LS_READ  = 3'd2;
  localparam logic [2:0] ST_LS_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  // The illegal size code 2'b11 falls into the word case.
  function automatic logic [CNT_W-1:0] size_bytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_bytes = CNT_W'(1);
      MEM_HALF: size_bytes = CNT_W'(2);
      default:  size_bytes = CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Memory controller serving I-cache line fills and LSB loads/stores over one
// byte-wide RAM/IO port, one request at a time with round-robin arbitration.
//
// state       | meaning
// ------------+----------------------------------------------------------
// ST_IDLE     | waiting for if_en / lsb_en, arbitrates on last_served
// ST_IF_READ  | issuing and capturing LINE_BYTES bytes into if_data
// ST_LS_READ  | issuing and capturing 1/2/4 bytes into lsb_rdata
// ST_LS_WRITE | writing 1/2/4 bytes, stalls on a full IO buffer
// ST_DONE     | single cycle with the done pulse high, then back to idle
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full,
  input  logic                      if_en,
  input  logic [31:0]               if_pc,
  output logic [ICACHE_BLOCK_W-1:0] if_data,
  output logic                      if_done,
  input  logic                      lsb_en,
  input  logic                      lsb_wr,
  input  logic [31:0]               lsb_addr,
  input  logic [1:0]                lsb_size,
  input  logic [31:0]               lsb_wdata,
  output logic [31:0]               lsb_rdata,
  output logic                      lsb_done
);

  logic [2:0]                state_q, state_d;
  logic                      last_lsb_q, last_lsb_d;
  logic [31:0]               base_q, base_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [31:0]               wdata_q, wdata_d;
  logic [31:0]               mem_a_q, mem_a_d;
  logic [7:0]                dout_q, dout_d;
  logic                      if_done_q, if_done_d;
  logic                      lsb_done_q, lsb_done_d;
  logic [ICACHE_BLOCK_W-1:0] line_q, line_d;
  logic [31:0]               rdata_q, rdata_d;

  logic [CNT_W-1:0] cnt_inc;
  logic [5:0]       cap_idx;
  logic [31:0]      next_a;
  logic             io_stall;
  logic             pick_if;
  logic             pick_ls;

  assign cnt_inc  = cnt_q + CNT_W'(1);
  // Data on mem_din belongs to the address issued one cycle earlier.
  assign cap_idx  = cnt_q[5:0] - 6'd1;
  assign next_a   = base_q + {{(32-CNT_W){1'b0}}, cnt_inc};
  assign io_stall = (base_q[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign pick_if  = if_en && (!lsb_en || last_lsb_q);
  assign pick_ls  = lsb_en && !pick_if;

  assign mem_wr    = rdy && (state_q == ST_LS_WRITE) && !io_stall;
  assign mem_a     = mem_a_q;
  assign mem_dout  = dout_q;
  assign if_data   = line_q;
  assign if_done   = if_done_q;
  assign lsb_rdata = rdata_q;
  assign lsb_done  = lsb_done_q;

  always_comb begin
    state_d    = state_q;
    last_lsb_d = last_lsb_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    mem_a_d    = mem_a_q;
    dout_d     = dout_q;
    if_done_d  = if_done_q;
    lsb_done_d = lsb_done_q;
    line_d     = line_q;
    rdata_d    = rdata_q;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (pick_if) begin
            state_d    = ST_IF_READ;
            base_d     = if_pc;
            len_d      = CNT_W'(LINE_BYTES);
            cnt_d      = '0;
            mem_a_d    = if_pc;
            last_lsb_d = 1'b0;
          end else if (pick_ls) begin
            state_d    = lsb_wr ? ST_LS_WRITE : ST_LS_READ;
            base_d     = lsb_addr;
            len_d      = size_bytes(lsb_size);
            cnt_d      = '0;
            wdata_d    = lsb_wdata;
            mem_a_d    = lsb_addr;
            dout_d     = lsb_wdata[7:0];
            last_lsb_d = 1'b1;
            if (!lsb_wr) rdata_d = '0;
          end
        end
        ST_IF_READ, ST_LS_READ: begin
          if (cnt_q != '0) begin
            if (state_q == ST_IF_READ) line_d[{cap_idx, 3'b000} +: 8] = mem_din;
            else                       rdata_d[{cap_idx[1:0], 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == len_q) begin
            state_d = ST_DONE;
            if (state_q == ST_IF_READ) if_done_d  = 1'b1;
            else                       lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc < len_q) mem_a_d = next_a;
          end
        end
        ST_LS_WRITE: begin
          if (!io_stall) begin
            if (cnt_inc == len_q) begin
              state_d    = ST_DONE;
              lsb_done_d = 1'b1;
            end else begin
              cnt_d   = cnt_inc;
              mem_a_d = next_a;
              dout_d  = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
            end
          end
        end
        ST_DONE: begin
          if_done_d  = 1'b0;
          lsb_done_d = 1'b0;
          state_d    = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_lsb_q <= 1'b1;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      mem_a_q    <= '0;
      dout_q     <= '0;
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      line_q     <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_lsb_q <= last_lsb_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      mem_a_q    <= mem_a_d;
      dout_q     <= dout_d;
      if_done_q  <= if_done_d;
      lsb_done_q <= lsb_done_d;
      line_q     <= line_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte RAM model, expectation queues for
// fills, loads and writes, and one task per scenario.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy = 1'b1;
  logic [7:0]   mem_din = 8'h00;
  logic [7:0]   mem_dout;
  logic [31:0]  mem_a;
  logic         mem_wr;
  logic         io_buffer_full = 1'b0;
  logic         if_en = 1'b0;
  logic [31:0]  if_pc = '0;
  logic [511:0] if_data;
  logic         if_done;
  logic         lsb_en = 1'b0;
  logic         lsb_wr = 1'b0;
  logic [31:0]  lsb_addr = '0;
  logic [1:0]   lsb_size = 2'b00;
  logic [31:0]  lsb_wdata = '0;
  logic [31:0]  lsb_rdata;
  logic         lsb_done;

  int total = 0;
  int bad   = 0;

  logic [7:0]   ram [0:262143];
  logic [511:0] if_exp_q [$];
  logic [31:0]  ls_exp_q [$];
  logic [39:0]  wr_exp_q [$];
  logic [39:0]  wr_log   [$];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_en(if_en), .if_pc(if_pc), .if_data(if_data), .if_done(if_done),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
    .lsb_wdata(lsb_wdata), .lsb_rdata(lsb_rdata), .lsb_done(lsb_done)
  );

  always #5 clk = ~clk;

  // The RAM port shares the global enable, so a paused system holds mem_din.
  always @(posedge clk) begin
    if (rdy) begin
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr) begin
        ram[mem_a[17:0]] <= mem_dout;
        wr_log.push_back({mem_a, mem_dout});
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b0; if_en = 1'b0; lsb_en = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Starts at the beginning of an idle cycle (cycle 0) and returns at the start
  // of the idle cycle after the last DONE.
  task automatic do_req(input bit use_if, input bit use_ls, input logic [31:0] pc,
                        input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, output int if_cyc, output int ls_cyc,
                        output logic [511:0] line, output logic [31:0] word);
    if_cyc = use_if ? -1 : 0;
    ls_cyc = use_ls ? -1 : 0;
    line = '0; word = '0;
    if_en = use_if; if_pc = pc;
    lsb_en = use_ls; lsb_wr = wr; lsb_addr = addr; lsb_size = size; lsb_wdata = wdata;
    for (int k = 1; k <= 300 && (if_cyc < 0 || ls_cyc < 0); k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (if_done && use_if && if_cyc < 0) begin if_cyc = k; line = if_data; if_en = 1'b0; end
      if (lsb_done && use_ls && ls_cyc < 0) begin ls_cyc = k; word = lsb_rdata; lsb_en = 1'b0; end
    end
    if_en = 1'b0; lsb_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0 || if_done !== 1'b0 ||
        lsb_done !== 1'b0 || if_data !== '0 || lsb_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got a=%h d=%h wr=%b ifd=%b lsd=%b rdata=%h want all zero",
               mem_a, mem_dout, mem_wr, if_done, lsb_done, lsb_rdata);
    end
    apply_reset();
  endtask

  task automatic test_loads();
    int ic, lc; logic [511:0] ln; logic [31:0] w, exp;
    ram[18'h200] = 8'h78; ram[18'h201] = 8'h56; ram[18'h202] = 8'h34; ram[18'h203] = 8'h12;
    ls_exp_q.push_back(32'h12345678);
    do_req(0, 1, '0, 1'b0, 32'h200, MEM_WORD, '0, ic, lc, ln, w);
    exp = ls_exp_q.pop_front();
    total++; if (lc != 6) begin bad++; $display("FAIL word_load_cycle: got %0d want 6", lc); end
    total++; if (w !== exp) begin bad++; $display("FAIL word_load_data: got %h want %h", w, exp); end
    ls_exp_q.push_back(32'h00001234);
    do_req(0, 1, '0, 1'b0, 32'h202, MEM_HALF, '0, ic, lc, ln, w);
    exp = ls_exp_q.pop_front();
    total++; if (lc != 4) begin bad++; $display("FAIL half_load_cycle: got %0d want 4", lc); end
    total++; if (w !== exp) begin bad++; $display("FAIL half_load_data: got %h want %h", w, exp); end
    ls_exp_q.push_back(32'h00000056);
    do_req(0, 1, '0, 1'b0, 32'h201, MEM_BYTE, '0, ic, lc, ln, w);
    exp = ls_exp_q.pop_front();
    total++; if (lc != 3) begin bad++; $display("FAIL byte_load_cycle: got %0d want 3", lc); end
    total++; if (w !== exp) begin bad++; $display("FAIL byte_load_data: got %h want %h", w, exp); end
  endtask

  task automatic test_store();
    int ic, lc; logic [511:0] ln; logic [31:0] w, exp; logic [39:0] e, a;
    wr_log.delete();
    for (int k = 0; k < 4; k++)
      wr_exp_q.push_back({32'h1000 + 32'(k), 8'(32'hA1B2C3D4 >> (8 * k))});
    io_buffer_full = 1'b1;
    do_req(0, 1, '0, 1'b1, 32'h1000, MEM_WORD, 32'hA1B2C3D4, ic, lc, ln, w);
    io_buffer_full = 1'b0;
    total++; if (lc != 5) begin bad++; $display("FAIL word_store_cycle: got %0d want 5", lc); end
    total++;
    if (wr_log.size() != 4) begin
      bad++; $display("FAIL word_store_count: got %0d want 4", wr_log.size());
      wr_exp_q.delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = wr_exp_q.pop_front(); a = wr_log[k];
        if (a !== e) begin bad++; $display("FAIL word_store_byte%0d: got %h want %h", k, a, e); end
      end
    end
    ls_exp_q.push_back(32'hA1B2C3D4);
    do_req(0, 1, '0, 1'b0, 32'h1000, MEM_WORD, '0, ic, lc, ln, w);
    exp = ls_exp_q.pop_front();
    total++; if (w !== exp) begin bad++; $display("FAIL store_readback: got %h want %h", w, exp); end
  endtask

  task automatic test_io_stall();
    int lc; bit stall_ok; bit wr4; logic [39:0] e;
    lc = -1; stall_ok = 1'b1; wr4 = 1'b0;
    wr_log.delete();
    wr_exp_q.push_back({32'h0003_0000, 8'h41});
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h0003_0000; lsb_size = MEM_BYTE; lsb_wdata = 32'h41;
    for (int k = 1; k <= 20 && lc < 0; k++) begin
      @(posedge clk); #1;
      io_buffer_full = (k <= 3);
      @(negedge clk);
      if (k <= 3 && mem_wr !== 1'b0) stall_ok = 1'b0;
      if (k == 4 && mem_wr === 1'b1 && mem_a === 32'h0003_0000 && mem_dout === 8'h41) wr4 = 1'b1;
      if (lsb_done) begin lc = k; lsb_en = 1'b0; end
    end
    io_buffer_full = 1'b0; lsb_en = 1'b0;
    @(posedge clk); #1;
    total++; if (!stall_ok) begin bad++; $display("FAIL io_stall_wr: got mem_wr=1 while full want 0"); end
    total++; if (!wr4) begin bad++; $display("FAIL io_write_cycle4: got no write of 41 want write in cycle 4"); end
    total++; if (lc != 5) begin bad++; $display("FAIL io_done_cycle: got %0d want 5", lc); end
    e = wr_exp_q.pop_front();
    total++;
    if (wr_log.size() != 1 || wr_log[0] !== e) begin
      bad++; $display("FAIL io_write_log: got %0d writes want one write %h", wr_log.size(), e);
    end
  endtask

  task automatic test_line_fill();
    logic [511:0] exp; int done_cyc; bit a_ok, wr_ok, again;
    done_cyc = -1; a_ok = 1'b1; wr_ok = 1'b1; again = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram[18'h100 + 18'(i)] = 8'(i);
      exp[8*i +: 8] = 8'(i);
    end
    if_exp_q.push_back(exp);
    if_en = 1'b1; if_pc = 32'h100;
    for (int k = 1; k <= 100 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (k <= 64 && mem_a !== 32'h100 + 32'(k - 1)) a_ok = 1'b0;
      if (mem_wr !== 1'b0) wr_ok = 1'b0;
      if (if_done) done_cyc = k;
    end
    exp = if_exp_q.pop_front();
    total++; if (done_cyc != 66) begin bad++; $display("FAIL fill_done_cycle: got %0d want 66", done_cyc); end
    total++; if (if_data !== exp) begin bad++; $display("FAIL fill_data: got %h want %h", if_data, exp); end
    total++; if (!a_ok) begin bad++; $display("FAIL fill_addr_seq: got wrong mem_a want 0x100+i in cycle 1+i"); end
    total++; if (!wr_ok) begin bad++; $display("FAIL fill_mem_wr: got 1 want 0"); end
    // if_en stays high across the DONE cycle; it must not be re-accepted there.
    @(posedge clk); #1;
    if_en = 1'b0;
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      if (if_done) again = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (again) begin bad++; $display("FAIL fill_reaccept: got second if_done want none"); end
  endtask

  task automatic test_arbitration();
    int ic, lc; logic [511:0] ln, el; logic [31:0] w, ew;
    // last served is IF here, so the LSB wins a simultaneous request.
    if_exp_q.push_back(if_exp_q.size() == 0 ? 512'h0 : 512'h0);
    void'(if_exp_q.pop_back());
    for (int i = 0; i < 64; i++) el[8*i +: 8] = 8'(i);
    if_exp_q.push_back(el); ls_exp_q.push_back(32'h12345678);
    do_req(1, 1, 32'h100, 1'b0, 32'h200, MEM_WORD, '0, ic, lc, ln, w);
    el = if_exp_q.pop_front(); ew = ls_exp_q.pop_front();
    total++; if (lc != 6 || ic != 73) begin bad++; $display("FAIL arb_lsb_first: got lsb=%0d if=%0d want 6 73", lc, ic); end
    total++; if (ln !== el || w !== ew) begin bad++; $display("FAIL arb_lsb_first_data: got %h want %h", w, ew); end
    apply_reset();
    for (int i = 0; i < 64; i++) el[8*i +: 8] = 8'(i);
    if_exp_q.push_back(el); ls_exp_q.push_back(32'h12345678);
    do_req(1, 1, 32'h100, 1'b0, 32'h200, MEM_WORD, '0, ic, lc, ln, w);
    el = if_exp_q.pop_front(); ew = ls_exp_q.pop_front();
    total++; if (ic != 66 || lc != 73) begin bad++; $display("FAIL arb_if_first: got if=%0d lsb=%0d want 66 73", ic, lc); end
    total++; if (ln !== el || w !== ew) begin bad++; $display("FAIL arb_if_first_data: got %h want %h", w, ew); end
  endtask

  task automatic test_rdy_freeze();
    logic [511:0] exp; int done_cyc; bit wr_ok; logic [31:0] a22, a26;
    done_cyc = -1; wr_ok = 1'b1; a22 = '0; a26 = '0;
    for (int i = 0; i < 64; i++) exp[8*i +: 8] = 8'(i);
    if_exp_q.push_back(exp);
    if_en = 1'b1; if_pc = 32'h100;
    for (int k = 1; k <= 120 && done_cyc < 0; k++) begin
      @(posedge clk); #1;
      rdy = !(k >= 20 && k <= 24);
      @(negedge clk);
      if (mem_wr !== 1'b0) wr_ok = 1'b0;
      if (k == 22) a22 = mem_a;
      if (k == 26) a26 = mem_a;
      if (if_done) begin done_cyc = k; if_en = 1'b0; end
    end
    rdy = 1'b1; if_en = 1'b0;
    @(posedge clk); #1;
    exp = if_exp_q.pop_front();
    total++; if (done_cyc != 71) begin bad++; $display("FAIL freeze_done_cycle: got %0d want 71", done_cyc); end
    total++; if (if_data !== exp) begin bad++; $display("FAIL freeze_data: got %h want %h", if_data, exp); end
    total++; if (a22 !== 32'h113 || a26 !== 32'h114) begin bad++; $display("FAIL freeze_addr_hold: got %h %h want 113 114", a22, a26); end
    total++; if (!wr_ok) begin bad++; $display("FAIL freeze_mem_wr: got 1 want 0"); end
  endtask

  task automatic test_async_reset();
    int ic, lc; logic [511:0] ln; logic [31:0] w, exp; logic [39:0] e;
    wr_log.delete();
    wr_exp_q.push_back({32'h1000, 8'hEF});
    wr_exp_q.push_back({32'h1001, 8'hBE});
    lsb_en = 1'b1; lsb_wr = 1'b1; lsb_addr = 32'h1000; lsb_size = MEM_WORD; lsb_wdata = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0; lsb_en = 1'b0;
    #1;
    total++;
    if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0 || lsb_done !== 1'b0 ||
        if_done !== 1'b0 || if_data !== '0 || lsb_rdata !== 32'h0) begin
      bad++; $display("FAIL async_reset_outputs: got a=%h d=%h wr=%b want all zero", mem_a, mem_dout, mem_wr);
    end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL async_reset_state: got %0d want %0d", dut.state_q, ST_IDLE); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if (wr_log.size() != 2) begin
      bad++; $display("FAIL async_reset_writes: got %0d writes want 2", wr_log.size());
      wr_exp_q.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        e = wr_exp_q.pop_front();
        if (wr_log[k] !== e) begin bad++; $display("FAIL async_reset_wr%0d: got %h want %h", k, wr_log[k], e); end
      end
    end
    ls_exp_q.push_back(32'hA1B2BEEF);
    do_req(0, 1, '0, 1'b0, 32'h1000, MEM_WORD, '0, ic, lc, ln, w);
    exp = ls_exp_q.pop_front();
    total++; if (lc != 6 || w !== exp) begin bad++; $display("FAIL post_reset_load: got %h at %0d want %h at 6", w, lc, exp); end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ram[i] = 8'(i * 7 + 3);
    test_reset();
    test_loads();
    test_store();
    test_io_stall();
    test_line_fill();
    test_arbitration();
    test_rdy_freeze();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
